// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, valid/ready output with one-byte holding register.
// Define UART_RX_PARITY_EN to expect an even-parity bit and add the parity_err output.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t        r_state;
  state_t        w_state_n;
  logic          r_meta;
  logic          r_sync;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_n;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_n;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_n;
  logic [7:0]    r_data;
  logic [7:0]    w_data_n;
  logic          r_valid;
  logic          w_valid_n;
  logic          r_ferr;
  logic          w_ferr_n;
  logic          r_ovr;
  logic          w_ovr_n;
  logic          w_xfer;
`ifdef UART_RX_PARITY_EN
  logic          r_par_bad;
  logic          w_par_bad_n;
  logic          r_perr;
  logic          w_perr_n;
`endif

  // Two-flop synchroniser; idle-high so reset to 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= rx;
      r_sync <= r_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_data  <= w_data_n;
      r_valid <= w_valid_n;
      r_ferr  <= w_ferr_n;
      r_ovr   <= w_ovr_n;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= w_par_bad_n;
      r_perr    <= w_perr_n;
`endif
    end
  end

  assign w_xfer = r_valid & rx_ready;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_data_n  = r_data;
    w_valid_n = r_valid & ~w_xfer;
    w_ferr_n  = 1'b0;
    w_ovr_n   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_n = r_par_bad;
    w_perr_n    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_n = '0;
        w_bit_n = '0;
        if (!r_sync) w_state_n = S_START;
      end
      S_START: begin
        if (r_cnt == HALF) begin
          w_cnt_n   = '0;
          w_state_n = r_sync ? S_IDLE : S_DATA;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == LAST) begin
          w_cnt_n = '0;
          w_shift_n[r_bit] = r_sync;
          if (r_bit == 3'd7) begin
            w_bit_n = '0;
`ifdef UART_RX_PARITY_EN
            w_state_n = S_PARITY;
`else
            w_state_n = S_STOP;
`endif
          end else begin
            w_bit_n = r_bit + 1'b1;
          end
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_cnt == LAST) begin
          w_cnt_n     = '0;
          w_par_bad_n = r_sync ^ (^r_shift);
          w_state_n   = S_STOP;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (r_cnt == LAST) begin
          w_cnt_n   = '0;
          w_state_n = S_IDLE;
          if (!r_sync) begin
            w_ferr_n = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (r_par_bad) begin
            w_perr_n = 1'b1;
`endif
          end else if (!r_valid || w_xfer) begin
            w_data_n  = r_shift;
            w_valid_n = 1'b1;
          end else begin
            w_ovr_n = 1'b1;
          end
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
        w_bit_n   = '0;
      end
    endcase
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign rx_busy   = (r_state != S_IDLE);
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: latency, handshake, overrun, framing, glitch, break, reset.
// With UART_RX_PARITY_EN defined it runs the parity scenarios at CLKS_PER_BIT=434.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam int CPB = 434;
`else
  localparam int CPB = 16;
`endif
  localparam int LAT = 2 + 1 + (CPB - 1) / 2 + 1 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int cyc = 0;
  int n_vrise = 0;
  int n_vcyc = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_busy = 0;
  int n_perr = 0;
  int t_rise = 0;
  int t_ferr = 0;
  logic       r_pv = 1'b0;
  logic [7:0] got [16];

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor; tasks only read these counters
  always @(negedge clk) begin
    r_pv <= rx_valid;
    if (rx_valid) n_vcyc <= n_vcyc + 1;
    if (rx_valid && !r_pv) begin
      got[n_vrise[3:0]] <= rx_data;
      n_vrise <= n_vrise + 1;
      t_rise  <= cyc;
    end
    if (frame_err) begin
      n_ferr <= n_ferr + 1;
      t_ferr <= cyc;
    end
    if (overrun) n_ovr <= n_ovr + 1;
    if (rx_busy) n_busy <= n_busy + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) n_perr <= n_perr + 1;
`endif
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stopb,
                            output int t0);
    @(negedge clk);
    rx = 1'b0;
    t0 = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stopb;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_par(input logic [7:0] d, input logic parb,
                          input logic stopb);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = parb;
    repeat (CPB) @(negedge clk);
    rx = stopb;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask
`endif

  task automatic test_reset;
    ticks(3);
    n_chk++;
    if ({rx_data, rx_valid, rx_busy, frame_err, overrun} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 000",
               {rx_data, rx_valid, rx_busy, frame_err, overrun});
    end
    rst = 1'b0;
    ticks(3 * CPB);
    n_chk++;
    if (rx_busy !== 1'b0 || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b valid=%b required 0 0",
               rx_busy, rx_valid);
    end
  endtask

  task automatic test_single;
    int b_r, b_c, b_f, b_o, t0, lat;
    rx_ready = 1'b1;
    b_r = n_vrise; b_c = n_vcyc; b_f = n_ferr; b_o = n_ovr;
    send_frame(8'hA5, 1'b1, t0);
    ticks(2 * CPB);
    n_chk++;
    if (n_vrise - b_r != 1 || n_vcyc - b_c != 1) begin
      n_fail++;
      $display("FAIL single_valid_pulse: rises=%0d cycles=%0d required 1 1",
               n_vrise - b_r, n_vcyc - b_c);
    end
    n_chk++;
    if (got[b_r[3:0]] !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_data: got %h required a5", got[b_r[3:0]]);
    end
    lat = t_rise - t0;
    n_chk++;
    if (lat < LAT - 1 || lat > LAT + 3) begin
      n_fail++;
      $display("FAIL single_latency: got %0d required %0d..%0d",
               lat, LAT - 1, LAT + 3);
    end
    n_chk++;
    if (n_ferr != b_f || n_ovr != b_o) begin
      n_fail++;
      $display("FAIL single_flags: ferr=%0d ovr=%0d required 0 0",
               n_ferr - b_f, n_ovr - b_o);
    end
  endtask

  task automatic test_overrun;
    int b_r, b_o, t0;
    rx_ready = 1'b0;
    b_r = n_vrise; b_o = n_ovr;
    send_frame(8'h3C, 1'b1, t0);
    ticks(CPB);
    n_chk++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL ovr_first: valid=%b data=%h required 1 3c",
               rx_valid, rx_data);
    end
    send_frame(8'hC3, 1'b1, t0);
    ticks(CPB);
    n_chk++;
    if (n_ovr - b_o != 1) begin
      n_fail++;
      $display("FAIL ovr_pulse: got %0d required 1", n_ovr - b_o);
    end
    n_chk++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h3C || n_vrise - b_r != 1) begin
      n_fail++;
      $display("FAIL ovr_retain: valid=%b data=%h rises=%0d required 1 3c 1",
               rx_valid, rx_data, n_vrise - b_r);
    end
    @(negedge clk);
    rx_ready = 1'b1;
    ticks(1);
    n_chk++;
    if (rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_consume: valid=%b required 0", rx_valid);
    end
  endtask

  task automatic test_glitch_break;
    int b_r, b_f, b_b, t0, k;
    rx_ready = 1'b1;
    b_r = n_vrise; b_f = n_ferr; b_b = n_busy;
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    ticks(3 * CPB);
    n_chk++;
    if (n_busy == b_b || rx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_start: busy_cycles=%0d busy_now=%b required >0 0",
               n_busy - b_b, rx_busy);
    end
    n_chk++;
    if (n_vrise != b_r || n_ferr != b_f) begin
      n_fail++;
      $display("FAIL glitch_silent: rises=%0d ferr=%0d required 0 0",
               n_vrise - b_r, n_ferr - b_f);
    end
    // Hold a break; release just after the third frame error
    @(negedge clk);
    rx = 1'b0;
    t0 = cyc;
    k = 0;
    while (n_ferr - b_f < 3 && k < 40 * CPB) begin
      ticks(1);
      k++;
    end
    rx = 1'b1;
    n_chk++;
    if (n_ferr - b_f != 3) begin
      n_fail++;
      $display("FAIL break_ferr_count: got %0d required 3", n_ferr - b_f);
    end
    n_chk++;
    if (t_ferr - t0 < 28 * CPB || t_ferr - t0 > 30 * CPB) begin
      n_fail++;
      $display("FAIL break_ferr_spacing: got %0d required %0d..%0d",
               t_ferr - t0, 28 * CPB, 30 * CPB);
    end
    ticks(3 * CPB);
    n_chk++;
    if (n_vrise != b_r || n_ferr - b_f != 3 || rx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL break_no_valid: rises=%0d ferr=%0d busy=%b required 0 3 0",
               n_vrise - b_r, n_ferr - b_f, rx_busy);
    end
  endtask

  task automatic test_frame_err;
    int b_r, b_f, t0;
    rx_ready = 1'b1;
    b_r = n_vrise; b_f = n_ferr;
    send_frame(8'h55, 1'b0, t0);
    ticks(2 * CPB);
    n_chk++;
    if (n_ferr - b_f != 1) begin
      n_fail++;
      $display("FAIL ferr_pulse: got %0d required 1", n_ferr - b_f);
    end
    n_chk++;
    if (n_vrise != b_r || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ferr_discard: rises=%0d valid=%b required 0 0",
               n_vrise - b_r, rx_valid);
    end
    rx_ready = 1'b0;
    send_frame(8'h0F, 1'b1, t0);
    ticks(CPB);
    n_chk++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h0F || n_ferr - b_f != 1) begin
      n_fail++;
      $display("FAIL ferr_recover: valid=%b data=%h ferr=%0d required 1 0f 1",
               rx_valid, rx_data, n_ferr - b_f);
    end
  endtask

  task automatic test_back_to_back;
    int b_r, b_f, b_o, t0;
    b_f = n_ferr; b_o = n_ovr;
    fork
      send_frame(8'h99, 1'b1, t0);
      begin
        ticks(5 * CPB + CPB / 2);
        rst = 1'b1;
        #1;
        n_chk++;
        if ({rx_data, rx_valid, rx_busy, frame_err, overrun} !== 12'h000) begin
          n_fail++;
          $display("FAIL midframe_reset: got %h required 000",
                   {rx_data, rx_valid, rx_busy, frame_err, overrun});
        end
      end
    join
    ticks(4);
    rst = 1'b0;
    ticks(2 * CPB);
    n_chk++;
    if (n_ferr != b_f || n_ovr != b_o || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abandon: ferr=%0d ovr=%0d valid=%b required 0 0 0",
               n_ferr - b_f, n_ovr - b_o, rx_valid);
    end
    rx_ready = 1'b1;
    b_r = n_vrise;
    send_frame(8'hFF, 1'b1, t0);
    send_frame(8'h00, 1'b1, t0);
    ticks(2 * CPB);
    n_chk++;
    if (n_vrise - b_r != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d required 2", n_vrise - b_r);
    end
    n_chk++;
    if (got[b_r[3:0]] !== 8'hFF || got[4'(b_r + 1)] !== 8'h00) begin
      n_fail++;
      $display("FAIL b2b_data: got %h %h required ff 00",
               got[b_r[3:0]], got[4'(b_r + 1)]);
    end
    n_chk++;
    if (n_ferr != b_f || n_ovr != b_o) begin
      n_fail++;
      $display("FAIL b2b_flags: ferr=%0d ovr=%0d required 0 0",
               n_ferr - b_f, n_ovr - b_o);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int b_r, b_f, b_p;
    rx_ready = 1'b1;
    b_r = n_vrise; b_f = n_ferr; b_p = n_perr;
    send_par(8'h81, 1'b0, 1'b1);
    ticks(CPB);
    n_chk++;
    if (n_vrise - b_r != 1 || got[b_r[3:0]] !== 8'h81 || n_perr != b_p) begin
      n_fail++;
      $display("FAIL par_good: rises=%0d data=%h perr=%0d required 1 81 0",
               n_vrise - b_r, got[b_r[3:0]], n_perr - b_p);
    end
    send_par(8'h81, 1'b1, 1'b1);
    ticks(CPB);
    n_chk++;
    if (n_perr - b_p != 1 || n_vrise - b_r != 1) begin
      n_fail++;
      $display("FAIL par_bad: perr=%0d rises=%0d required 1 1",
               n_perr - b_p, n_vrise - b_r);
    end
    send_par(8'h81, 1'b1, 1'b0);
    ticks(2 * CPB);
    n_chk++;
    if (n_ferr - b_f != 1 || n_perr - b_p != 1 || n_vrise - b_r != 1) begin
      n_fail++;
      $display("FAIL par_ferr_prec: ferr=%0d perr=%0d rises=%0d required 1 1 1",
               n_ferr - b_f, n_perr - b_p, n_vrise - b_r);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b0;
    test_reset();
`ifdef UART_RX_PARITY_EN
    test_parity();
`else
    test_single();
    test_overrun();
    test_glitch_break();
    test_frame_err();
    test_back_to_back();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
